// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
//   Memory-access stage of a 5-stage RV32I pipeline (between EX/MEM and MEM/WB).
//   Loads and stores go to a data-memory port with a req/ready handshake.
//   Sub-word accesses are lane-aligned, byte-enabled and sign/zero-extended.
//   Non-memory instructions pass their ALU result to writeback after one cycle.
//
//   Build option:
//     MEM_MISALIGN_TRAP_EN  defined   -> misaligned H/W accesses issue no memory
//                                       request and complete in one cycle with
//                                       misalign_out=1 and Reg_WB_out=0.
//                           undefined -> misaligned addresses are aligned down;
//                                       misalign_out is tied to 0.
//
//   Ports
//     clk, reset                   clock, asynchronous active-low reset
//     valid_in .. Reg_WB_in        instruction from EX/MEM
//     stall_out                    upstream holds its inputs this cycle
//     dmem_req/we/addr/be/wdata    memory request (stable while BUSY)
//     dmem_ready, dmem_rdata       memory completion and read data
//     valid_out, wb_data_out,
//     Rd_out, Reg_WB_out,
//     misalign_out                 registered result towards MEM/WB
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module mem_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic                  mem_read_in,
    input  logic                  mem_write_in,
    input  logic [2:0]            funct3_in,
    input  logic [XLEN-1:0]       addr_in,
    input  logic [XLEN-1:0]       store_data_in,
    input  logic [REG_ADDR_W-1:0] Rd_in,
    input  logic                  Reg_WB_in,
    output logic                  stall_out,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [XLEN-1:0]       dmem_addr,
    output logic [3:0]            dmem_be,
    output logic [XLEN-1:0]       dmem_wdata,
    input  logic                  dmem_ready,
    input  logic [XLEN-1:0]       dmem_rdata,
    output logic                  valid_out,
    output logic [XLEN-1:0]       wb_data_out,
    output logic [REG_ADDR_W-1:0] Rd_out,
    output logic                  Reg_WB_out,
    output logic                  misalign_out
);

    typedef enum logic { IDLE, BUSY } state_t;
    typedef enum logic [1:0] { SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2 } size_t;

    state_t                state_q, state_d;

    // Request latched on entry to BUSY; drives dmem_* directly so it is stable.
    logic [XLEN-1:0]       maddr_q, maddr_d;
    logic [1:0]            lane_q, lane_d;
    logic [3:0]            be_q, be_d;
    logic [XLEN-1:0]       wdata_q, wdata_d;
    logic                  we_q, we_d;
    size_t                 size_q, size_d;
    logic                  uns_q, uns_d;
    logic [REG_ADDR_W-1:0] rd_lat_q, rd_lat_d;
    logic                  regwb_lat_q, regwb_lat_d;

    // Result registers
    logic                  valid_q, valid_d;
    logic [XLEN-1:0]       wb_q, wb_d;
    logic [REG_ADDR_W-1:0] rd_out_q, rd_out_d;
    logic                  regwb_out_q, regwb_out_d;
`ifdef MEM_MISALIGN_TRAP_EN
    logic                  misalign_q, misalign_d;
    logic                  misalign;
`endif

    // ---------------- request decode ----------------
    logic            is_mem;
    size_t           size;
    logic            uns;
    logic [1:0]      lane;
    logic [3:0]      be;
    logic [XLEN-1:0] wdata;

    always_comb begin
        is_mem = mem_read_in | mem_write_in;
        unique case (funct3_in)
            3'b000, 3'b100: size = SZ_B;
            3'b001, 3'b101: size = SZ_H;
            default:        size = SZ_W;
        endcase
        uns = (funct3_in == 3'b100) | (funct3_in == 3'b101);

        // Lane is the size-aligned byte offset; with the trap enabled any
        // misaligned access never reaches memory, so aligning is harmless.
        unique case (size)
            SZ_B:    lane = addr_in[1:0];
            SZ_H:    lane = {addr_in[1], 1'b0};
            default: lane = 2'b00;
        endcase

        unique case (size)
            SZ_B:    be = 4'b0001 << lane;
            SZ_H:    be = 4'b0011 << lane;
            default: be = 4'b1111;
        endcase

        unique case (size)
            SZ_B:    wdata = {4{store_data_in[7:0]}};
            SZ_H:    wdata = {2{store_data_in[15:0]}};
            default: wdata = store_data_in;
        endcase
    end

`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign = ((size == SZ_H) & addr_in[0]) |
                      ((size == SZ_W) & (addr_in[1:0] != 2'b00));
`endif

    // ---------------- load formatting ----------------
    logic [XLEN-1:0] rshift;
    logic [XLEN-1:0] load_val;

    always_comb begin
        rshift = dmem_rdata >> {lane_q, 3'b000};
        unique case (size_q)
            SZ_B:    load_val = uns_q ? {24'b0, rshift[7:0]}
                                      : {{24{rshift[7]}}, rshift[7:0]};
            SZ_H:    load_val = uns_q ? {16'b0, rshift[15:0]}
                                      : {{16{rshift[15]}}, rshift[15:0]};
            default: load_val = dmem_rdata;
        endcase
    end

    // ---------------- next state / outputs ----------------
    always_comb begin
        state_d     = state_q;
        maddr_d     = maddr_q;
        lane_d      = lane_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        size_d      = size_q;
        uns_d       = uns_q;
        rd_lat_d    = rd_lat_q;
        regwb_lat_d = regwb_lat_q;
        valid_d     = 1'b0;          // bubble unless something completes
        wb_d        = wb_q;
        rd_out_d    = rd_out_q;
        regwb_out_d = 1'b0;          // write enable only alongside valid_out
`ifdef MEM_MISALIGN_TRAP_EN
        misalign_d  = 1'b0;
`endif
        stall_out   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (valid_in && !is_mem) begin
                    valid_d     = 1'b1;
                    wb_d        = addr_in;
                    rd_out_d    = Rd_in;
                    regwb_out_d = Reg_WB_in;
`ifdef MEM_MISALIGN_TRAP_EN
                end else if (valid_in && misalign) begin
                    valid_d     = 1'b1;
                    wb_d        = addr_in;
                    rd_out_d    = Rd_in;
                    misalign_d  = 1'b1;
`endif
                end else if (valid_in) begin
                    stall_out   = 1'b1;
                    state_d     = BUSY;
                    maddr_d     = {addr_in[XLEN-1:2], 2'b00};
                    lane_d      = lane;
                    be_d        = be;
                    wdata_d     = wdata;
                    we_d        = mem_write_in & ~mem_read_in;  // rd wins
                    size_d      = size;
                    uns_d       = uns;
                    rd_lat_d    = Rd_in;
                    regwb_lat_d = Reg_WB_in;
                end
            end
            BUSY: begin
                if (dmem_ready) begin
                    state_d     = IDLE;
                    valid_d     = 1'b1;
                    wb_d        = we_q ? maddr_q : load_val;
                    rd_out_d    = rd_lat_q;
                    regwb_out_d = regwb_lat_q;
                end else begin
                    stall_out   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            maddr_q     <= '0;
            lane_q      <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            size_q      <= SZ_W;
            uns_q       <= 1'b0;
            rd_lat_q    <= '0;
            regwb_lat_q <= 1'b0;
            valid_q     <= 1'b0;
            wb_q        <= '0;
            rd_out_q    <= '0;
            regwb_out_q <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            maddr_q     <= maddr_d;
            lane_q      <= lane_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            rd_lat_q    <= rd_lat_d;
            regwb_lat_q <= regwb_lat_d;
            valid_q     <= valid_d;
            wb_q        <= wb_d;
            rd_out_q    <= rd_out_d;
            regwb_out_q <= regwb_out_d;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_q  <= misalign_d;
`endif
        end
    end

    assign dmem_req    = (state_q == BUSY);
    assign dmem_we     = (state_q == BUSY) & we_q;
    assign dmem_addr   = maddr_q;
    assign dmem_be     = be_q;
    assign dmem_wdata  = wdata_q;
    assign valid_out   = valid_q;
    assign wb_data_out = wb_q;
    assign Rd_out      = rd_out_q;
    assign Reg_WB_out  = regwb_out_q;
`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign_out = misalign_q;
`else
    assign misalign_out = 1'b0;
`endif

endmodule
